serial_add_ctrl: RTL and testbench

//  Bit-serial add/subtract engine that sequences one full-adder cell (fa_module) over WIDTH

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/fa_module.sv | 13 +
 rtl/serial_add_ctrl.sv | 116 +++++++++++
 tb/tb_serial_add_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared state encoding and width limits for the bit-serial add/subtract engine.
package serial_add_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } sa_state_t;

    localparam int SA_MIN_WIDTH = 2;
    localparam int SA_MAX_WIDTH = 32;

endpackage

// File: rtl/fa_module.sv
// Combinational single-bit full adder cell, sequenced by serial_add_ctrl.
module fa_module (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full-adder cell stepped over WIDTH bits, LSB first,
// with valid/ready handshakes on both the operand and the result side.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < SA_MIN_WIDTH || WIDTH > SA_MAX_WIDTH) begin : g_bad_width
            $error("serial_add_ctrl: WIDTH must be within 2..32");
        end
    endgenerate

    sa_state_t        state_reg;
    sa_state_t        state_next;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [WIDTH-1:0] b_eff;
    logic             fa_s;
    logic             fa_cout;
    logic             last_bit;

    // Subtraction is a + ~b + 1: invert B here, the +1 comes from the preset carry FF.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b_inv
            assign b_eff[gi] = b[gi] ^ sub;
        end
    endgenerate

    fa_module u_fa (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .cin  (carry_reg),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit  = (cnt_reg == CNT_LAST);
    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = (state_reg == S_DONE);
    assign sum       = res_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (in_valid) state_next = S_RUN;
            S_RUN:   if (last_bit) state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b_eff;
                        carry_reg <= sub;
                        cnt_reg   <= '0;
                    end
                end
                S_RUN: begin
                    res_reg   <= {fa_s, res_reg[WIDTH-1:1]};
                    a_sh_reg  <= {1'b0, a_sh_reg[WIDTH-1:1]};
                    b_sh_reg  <= {1'b0, b_sh_reg[WIDTH-1:1]};
                    carry_reg <= fa_cout;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    // On the MSB step carry_reg still holds the carry into the MSB.
                    if (last_bit) begin
                        cout_reg <= fa_cout;
                        ovf_reg  <= carry_reg ^ fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and back-to-back random checks of serial_add_ctrl at WIDTH 8, 2 and 32.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid8 = 0, in_ready8, sub8 = 0, out_valid8, out_ready8 = 0, cout8, ovf8;
    logic [7:0]  a8 = 0, b8 = 0, sum8;
    logic        in_valid2 = 0, in_ready2, sub2 = 0, out_valid2, out_ready2 = 0, cout2, ovf2;
    logic [1:0]  a2 = 0, b2 = 0, sum2;
    logic        in_valid32 = 0, in_ready32, sub32 = 0, out_valid32, out_ready32 = 0, cout32, ovf32;
    logic [31:0] a32 = 0, b32 = 0, sum32;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8),
        .ovf(ovf8));

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
        .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2), .cout(cout2),
        .ovf(ovf2));

    serial_add_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .a(a32), .b(b32),
        .sub(sub32), .out_valid(out_valid32), .out_ready(out_ready32), .sum(sum32),
        .cout(cout32), .ovf(ovf32));

    // Reference: wide add of a + (sub ? ~b : b) + sub, overflow from operand/result signs.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] sm, output logic co,
                                  output logic ov);
        logic [63:0] mask, be, t;
        mask = (64'd1 << w) - 64'd1;
        be   = s ? (~{32'd0, b} & mask) : {32'd0, b};
        t    = {32'd0, a} + be + {63'd0, s};
        sm   = t[31:0] & mask[31:0];
        co   = t[w];
        ov   = (a[w-1] == be[w-1]) && (sm[w-1] != a[w-1]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready8, out_valid8);
        end
        checks++;
        if (sum8 !== 8'h00 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_result: sum=%h cout=%b ovf=%b required 00/0/0", sum8, cout8, ovf8);
        end
        $display("reset: in_ready=%b out_valid=%b sum=%h", in_ready8, out_valid8, sum8);
    endtask

    // One WIDTH=8 op: accept, measure latency, check result, release and check return to IDLE.
    task automatic run_op8(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic [7:0] esum, input logic ecout,
                           input logic eovf);
        int n;
        n = 0;
        while (in_ready8 !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        in_valid8 = 1'b1; a8 = a; b8 = b; sub8 = s;
        tick();
        in_valid8 = 1'b0;
        n = 0;
        while (out_valid8 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL %s_latency: %0d edges required 8", name, n);
        end
        checks++;
        if (sum8 !== esum || cout8 !== ecout || ovf8 !== eovf) begin
            errors++;
            $display("FAIL %s_result: sum=%h cout=%b ovf=%b required %h/%b/%b",
                     name, sum8, cout8, ovf8, esum, ecout, eovf);
        end
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b required 0/1",
                     name, out_valid8, in_ready8);
        end
        $display("op %s: a=%h b=%h sub=%b -> sum=%h cout=%b ovf=%b", name, a, b, s, sum8, cout8, ovf8);
    endtask

    task automatic test_add();
        run_op8("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        run_op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_sub();
        run_op8("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op8("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    endtask

    task automatic test_backpressure();
        int n;
        in_valid8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0;
        tick();
        in_valid8 = 1'b0;
        n = 0;
        while (out_valid8 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'hAA; sub8 = 1'b1;
            tick();
            checks++;
            if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || sum8 !== 8'h46 ||
                cout8 !== 1'b0 || ovf8 !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b sum=%h required 1/0/46",
                         i, out_valid8, in_ready8, sum8);
            end
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || sum8 !== 8'h46) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b sum=%h required 0/1/46",
                     out_valid8, in_ready8, sum8);
        end
        $display("backpressure: held sum=%h for 5 cycles, released", sum8);
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b0;
        tick();
        in_valid8 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || sum8 !== 8'h00) begin
            errors++;
            $display("FAIL midrst_state: in_ready=%b out_valid=%b sum=%h required 1/0/00",
                     in_ready8, out_valid8, sum8);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid8 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midrst_no_valid: out_valid rose=1 required 0");
        end
        $display("reset mid-run: op dropped, out_valid seen=%b", seen);
        run_op8("after_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back_w2();
        int prev, n;
        logic [31:0] ra, rb, es;
        logic rs, ec, eo;
        out_ready2 = 1'b1;
        prev = -1;
        for (int i = 0; i < 12; i++) begin
            ra = $urandom_range(0, 3); rb = $urandom_range(0, 3); rs = 1'($urandom_range(0, 1));
            model(2, ra, rb, rs, es, ec, eo);
            in_valid2 = 1'b1; a2 = ra[1:0]; b2 = rb[1:0]; sub2 = rs;
            tick();
            if (prev >= 0) begin
                checks++;
                if (cyc - prev !== 4) begin
                    errors++;
                    $display("FAIL w2_period%0d: %0d cycles required 4", i, cyc - prev);
                end
            end
            prev = cyc;
            n = 0;
            while (out_valid2 !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (n !== 2 || sum2 !== es[1:0] || cout2 !== ec || ovf2 !== eo) begin
                errors++;
                $display("FAIL w2_op%0d: lat=%0d sum=%h cout=%b ovf=%b required 2/%h/%b/%b",
                         i, n, sum2, cout2, ovf2, es[1:0], ec, eo);
            end
            $display("w2 op%0d: a=%h b=%h sub=%b -> sum=%h cout=%b ovf=%b",
                     i, ra[1:0], rb[1:0], rs, sum2, cout2, ovf2);
            tick();
        end
        in_valid2 = 1'b0;
        out_ready2 = 1'b0;
    endtask

    task automatic test_back_to_back_w32();
        int prev, n;
        logic [31:0] ra, rb, es;
        logic rs, ec, eo;
        out_ready32 = 1'b1;
        prev = -1;
        for (int i = 0; i < 10; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            if (i == 0) begin ra = 32'h7FFF_FFFF; rb = 32'h0000_0001; rs = 1'b0; end
            if (i == 1) begin ra = 32'h8000_0000; rb = 32'h0000_0001; rs = 1'b1; end
            model(32, ra, rb, rs, es, ec, eo);
            in_valid32 = 1'b1; a32 = ra; b32 = rb; sub32 = rs;
            tick();
            if (prev >= 0) begin
                checks++;
                if (cyc - prev !== 34) begin
                    errors++;
                    $display("FAIL w32_period%0d: %0d cycles required 34", i, cyc - prev);
                end
            end
            prev = cyc;
            n = 0;
            while (out_valid32 !== 1'b1 && n < 60) begin
                tick();
                n++;
            end
            checks++;
            if (n !== 32 || sum32 !== es || cout32 !== ec || ovf32 !== eo) begin
                errors++;
                $display("FAIL w32_op%0d: lat=%0d sum=%h cout=%b ovf=%b required 32/%h/%b/%b",
                         i, n, sum32, cout32, ovf32, es, ec, eo);
            end
            $display("w32 op%0d: a=%h b=%h sub=%b -> sum=%h cout=%b ovf=%b",
                     i, ra, rb, rs, sum32, cout32, ovf32);
            tick();
        end
        in_valid32 = 1'b0;
        out_ready32 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back_w2();
        test_back_to_back_w32();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
